// File: rtl/reg_bank_wr_arbiter.sv
// reg_bank_wr_arbiter
//   Round-robin write arbiter and sequencer for a shared register bank.
//   Requesters offer addr/data with a valid/ready handshake. One requester
//   is granted per cycle. A granted requester may hold a lock for up to
//   MAX_BURST beats. Accepted writes are registered onto a one-hot
//   write-enable vector and a shared data bus for the bank.
//
// Ports
//   clk        : clock, rising edge
//   arst_in    : asynchronous reset, active-high
//   stall_in   : freezes arbitration, no transfers while high
//   req_valid  : per-requester request valid
//   req_lock   : per-requester burst-lock request, sampled with valid
//   req_addr   : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   : packed data, requester i at [i*WIDTH +: WIDTH]
//   req_ready  : one-hot or zero grant; transfer = valid & ready
//   reg_we     : registered one-hot write enable to the bank
//   reg_din    : registered write data to every bank register
//   err_addr   : registered one-cycle pulse on an out-of-range address
module reg_bank_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned WIDTH     = 20,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      arst_in,
  input  logic                      stall_in,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REGS-1:0]       reg_we,
  output logic [WIDTH-1:0]          reg_din,
  output logic                      err_addr
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [NUM_REGS-1:0] reg_we_q, reg_we_d;
  logic [WIDTH-1:0]    reg_din_q, reg_din_d;
  logic                err_addr_q, err_addr_d;

  // Arbitration
  logic [2*NUM_REQ-1:0] rot_valid;
  logic                 found;
  int unsigned          k_sel;
  logic [PTR_W-1:0]     idle_idx;
  logic [NUM_REQ-1:0]   gnt_oh;

  // Valid vector is doubled and rotated by ptr so the first set bit gives
  // the wrap-around offset from ptr without variable indexing.
  always_comb begin
    rot_valid = {req_valid, req_valid} >> ptr_q;
    found     = 1'b0;
    k_sel     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && rot_valid[k]) begin
        found = 1'b1;
        k_sel = k;
      end
    end
    idle_idx = PTR_W'((32'(ptr_q) + k_sel) % NUM_REQ);

    gnt_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (state_q == ST_IDLE) begin
        gnt_oh[i] = found && (idle_idx == PTR_W'(i));
      end else begin
        gnt_oh[i] = req_valid[i] && (owner_q == PTR_W'(i));
      end
    end

    // Reset also masks the grant so nothing is accepted while it is held.
    req_ready = (arst_in || stall_in) ? '0 : gnt_oh;
  end

  // Selected transfer (ready already implies valid)
  logic              xfer;
  logic [PTR_W-1:0]  sel_idx;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_data;

  always_comb begin
    xfer     = |req_ready;
    sel_idx  = '0;
    sel_lock = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_idx  = PTR_W'(i);
        sel_lock = req_lock[i];
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // FSM / pointer / burst counter
  logic [CNT_W-1:0] cnt_inc;
  logic             release_lock;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    burst_cnt_d  = burst_cnt_q;
    cnt_inc      = burst_cnt_q + 1'b1;
    release_lock = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          ptr_d = PTR_W'((32'(sel_idx) + 1) % NUM_REQ);
          if (sel_lock && (MAX_BURST > 1)) begin
            state_d     = ST_BURST;
            owner_d     = sel_idx;
            burst_cnt_d = CNT_W'(1);
          end
        end
      end
      ST_BURST: begin
        if (!stall_in) begin
          if (xfer) begin
            burst_cnt_d  = cnt_inc;
            release_lock = !sel_lock || (32'(cnt_inc) == MAX_BURST);
          end else begin
            // Owner dropped valid: give the bus back.
            release_lock = 1'b1;
          end
          if (release_lock) begin
            state_d     = ST_IDLE;
            ptr_d       = PTR_W'((32'(owner_q) + 1) % NUM_REQ);
            burst_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write stage
  logic addr_ok;

  always_comb begin
    addr_ok = 32'(sel_addr) < NUM_REGS;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      reg_we_d[r] = xfer && addr_ok && (32'(sel_addr) == r);
    end
    err_addr_d = xfer && !addr_ok;
    reg_din_d  = xfer ? sel_data : reg_din_q;
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      reg_we_q    <= '0;
      reg_din_q   <= '0;
      err_addr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      reg_we_q    <= reg_we_d;
      reg_din_q   <= reg_din_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign reg_we   = reg_we_q;
  assign reg_din  = reg_din_q;
  assign err_addr = err_addr_q;

endmodule
